// File: rtl/data_skid_stage.sv
// -----------------------------------------------------------------------------
// data_skid_stage
//
// Two-entry valid/ready skid buffer. All outputs come straight from flops, so
// there is no combinational path from iReady to oReady or from iValid/iData to
// oValid/oData. A main register drives oData and a skid register catches the
// word that arrives while the downstream side stalls.
//
// States:
//   EMPTY : no word held            oValid=0 oReady=1
//   BUSY  : one word in main        oValid=1 oReady=1
//   FULL  : main + skid both held   oValid=1 oReady=0
//
// Parameters:
//   WIDTH        data bits per word (1..256)
//
// Ports:
//   iClk         clock, rising edge
//   iReset       asynchronous active-high reset
//   iData        upstream word
//   iValid       upstream word present
//   oReady       stage can accept a word (registered)
//   oData        downstream word (registered, main register)
//   oValid       oData valid (registered)
//   iReady       downstream accepts oData
//   oStallCount  saturating count of stalled cycles (oValid=1, iReady=0);
//                present only when DATA_SKID_STAGE_STALLCNT_EN is defined
//
// Optional feature macro: DATA_SKID_STAGE_STALLCNT_EN
// -----------------------------------------------------------------------------
module data_skid_stage #(
  parameter int WIDTH = 32
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic [WIDTH-1:0] iData,
  input  logic             iValid,
  output logic             oReady,
  output logic [WIDTH-1:0] oData,
  output logic             oValid,
  input  logic             iReady
`ifdef DATA_SKID_STAGE_STALLCNT_EN
  ,
  output logic [15:0]      oStallCount
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_valid;
  logic             r_ready;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_load_main;
  logic             w_main_from_skid;
  logic             w_load_skid;
  logic [WIDTH-1:0] w_main_nxt;

  // Handshakes use the registered flags, never the inputs' reverse direction.
  assign w_in_xfer  = iValid & r_ready;
  assign w_out_xfer = r_valid & iReady;

  // Next-state and register load enables.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = ST_BUSY;
          w_load_main = 1'b1;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_BUSY: begin
        if (w_in_xfer && w_out_xfer) begin
          w_state_nxt = ST_BUSY;
          w_load_main = 1'b1;
        end else if (w_in_xfer) begin
          // Downstream stalled: park the new word in the skid register.
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_FULL: begin
        // oReady is low here, so only the output side can move.
        if (w_out_xfer) begin
          w_state_nxt      = ST_BUSY;
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Source of the next main-register word.
  always_comb begin
    if (w_main_from_skid) begin
      w_main_nxt = r_skid;
    end else begin
      w_main_nxt = iData;
    end
  end

  // State register with registered valid/ready flags derived from next state.
  // r_ready stays low through reset and rises on the first edge after release.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt != ST_EMPTY);
      r_ready <= (w_state_nxt != ST_FULL);
    end
  end

  // Main and skid data registers.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_main <= {WIDTH{1'b0}};
      r_skid <= {WIDTH{1'b0}};
    end else begin
      if (w_load_main) begin
        r_main <= w_main_nxt;
      end
      if (w_load_skid) begin
        r_skid <= iData;
      end
    end
  end

  assign oValid = r_valid;
  assign oReady = r_ready;
  assign oData  = r_main;

`ifdef DATA_SKID_STAGE_STALLCNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of edges where a presented word was not taken.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_stall_cnt <= 16'h0000;
    end else if (r_valid && !iReady && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign oStallCount = r_stall_cnt;
`endif

endmodule

// File: tb/tb_data_skid_stage.sv
module tb_data_skid_stage;

  localparam int W = 8;

  logic         iClk = 1'b0;
  logic         iReset;
  logic [W-1:0] iData;
  logic         iValid;
  logic         oReady;
  logic [W-1:0] oData;
  logic         oValid;
  logic         iReady;
`ifdef DATA_SKID_STAGE_STALLCNT_EN
  logic [15:0]  oStallCount;
`endif

  data_skid_stage #(.WIDTH(W)) dut (
    .iClk   (iClk),
    .iReset (iReset),
    .iData  (iData),
    .iValid (iValid),
    .oReady (oReady),
    .oData  (oData),
    .oValid (oValid),
    .iReady (iReady)
`ifdef DATA_SKID_STAGE_STALLCNT_EN
    ,
    .oStallCount (oStallCount)
`endif
  );

  always #5 iClk = ~iClk;

  int tests = 0;
  int fails = 0;

  // Reference model: the stage is a FIFO of at most two words.
  logic [W-1:0] sb[$];      // words accepted, not yet emitted (scoreboard)
  int           mcnt = 0;   // occupancy
  bit           mrdy = 1'b0; // model ready (low until first edge after reset)
  logic [15:0]  mstall = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a word that will be
  // taken at the coming edge, and checks words are held during stalls.
  bit           prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [W-1:0] exp_w;
  always @(negedge iClk) begin
    if (iReset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", {31'd0, oValid}, 32'd1);
        chk("hold_data", {24'd0, oData}, {24'd0, prev_data});
      end
      if (oValid && iReady) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: got word %0h expected none", oData);
        end else begin
          exp_w = sb.pop_front();
          chk("sb_data", {24'd0, oData}, {24'd0, exp_w});
        end
      end
      prev_hold = oValid && !iReady;
      prev_data = oData;
    end
  end

  // One clock cycle: drive, check flags against model, advance model.
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit r);
    bit in_x;
    bit out_x;
    iValid = v;
    iData  = d;
    iReady = r;
    @(negedge iClk);
    chk("ovalid", {31'd0, oValid}, {31'd0, (mcnt > 0)});
    chk("oready", {31'd0, oReady}, {31'd0, mrdy});
`ifdef DATA_SKID_STAGE_STALLCNT_EN
    chk("stall_cnt", {16'd0, oStallCount}, {16'd0, mstall});
`endif
    @(posedge iClk);
    in_x  = v && mrdy;
    out_x = (mcnt > 0) && r;
    if ((mcnt > 0) && !r && (mstall != 16'hFFFF)) mstall = mstall + 16'd1;
    if (in_x) sb.push_back(d);
    mcnt = mcnt + int'(in_x) - int'(out_x);
    mrdy = (mcnt < 2);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; an offered word is held at iValid
  // across release to show nothing is taken before the first edge.
  task automatic do_reset();
    #2 iReset = 1'b1;
    #1;
    chk("rst_ovalid", {31'd0, oValid}, 32'd0);
    chk("rst_oready", {31'd0, oReady}, 32'd0);
    chk("rst_odata", {24'd0, oData}, 32'd0);
`ifdef DATA_SKID_STAGE_STALLCNT_EN
    chk("rst_stall", {16'd0, oStallCount}, 32'd0);
`endif
    sb.delete();
    mcnt   = 0;
    mrdy   = 1'b0;
    mstall = 16'h0000;
    iValid = 1'b1;
    iData  = 8'h77;
    iReady = 1'b1;
    @(negedge iClk);
    #1 iReset = 1'b0;
    @(posedge iClk);
    #1;
    mrdy = 1'b1;
    chk("rel_oready", {31'd0, oReady}, 32'd1);
    chk("rel_ovalid", {31'd0, oValid}, 32'd0);
  endtask

  initial begin
    iReset = 1'b1;
    iValid = 1'b0;
    iData  = 8'h00;
    iReady = 1'b0;
    #12;
    chk("init_ovalid", {31'd0, oValid}, 32'd0);
    chk("init_oready", {31'd0, oReady}, 32'd0);
    chk("init_odata", {24'd0, oData}, 32'd0);
    @(negedge iClk);
    #1 iReset = 1'b0;
    @(posedge iClk);
    #1;
    mrdy = 1'b1;
    chk("first_oready", {31'd0, oReady}, 32'd1);

    // Streaming 1..100: each word visible one cycle after acceptance.
    for (int k = 1; k <= 100; k++) begin
      cycle(1'b1, 8'(k), 1'b1);
      chk("stream_lat", {24'd0, oData}, k);
    end
    cycle(1'b0, 8'h00, 1'b1);

    // Backpressure: A then B with downstream stalled.
    cycle(1'b1, 8'h0A, 1'b0);
    cycle(1'b1, 8'h0B, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("bp_full_odata", {24'd0, oData}, 32'h0A);
    chk("bp_full_oready", {31'd0, oReady}, 32'd0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("bp_second", {24'd0, oData}, 32'h0B);
    chk("bp_ready_back", {31'd0, oReady}, 32'd1);
    cycle(1'b0, 8'h00, 1'b1);

    // Simultaneous transfer in BUSY.
    cycle(1'b1, 8'h05, 1'b0);
    cycle(1'b1, 8'h06, 1'b1);
    chk("simul_odata", {24'd0, oData}, 32'h06);
    chk("simul_oready", {31'd0, oReady}, 32'd1);
    chk("simul_ovalid", {31'd0, oValid}, 32'd1);
    cycle(1'b0, 8'h00, 1'b1);

    // Reset mid-stream while FULL with A,B; they must never appear.
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b1, 8'hBB, 1'b0);
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b1, 8'(8'h30 + k), 1'b1);

    // Random valid/ready traffic.
    for (int k = 0; k < 6000; k++) begin
      cycle(($urandom_range(0, 99) < 70), 8'($urandom), ($urandom_range(0, 99) < 60));
    end
    for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b1);
    chk("drain_empty", sb.size(), 32'd0);

`ifdef DATA_SKID_STAGE_STALLCNT_EN
    // Stall counter saturation.
    do_reset();
    cycle(1'b1, 8'h5A, 1'b0);
    for (int k = 0; k < 65540; k++) cycle(1'b0, 8'h00, 1'b0);
    chk("stall_sat", {16'd0, oStallCount}, 32'h0000FFFF);
    cycle(1'b0, 8'h00, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
